// File: rtl/pwm_frontend_pkg.sv
// Shared constants and helpers for the PWM-DAC analog front end model.
package pwm_frontend_pkg;

    localparam real ALPHA_DEF = 0.007;
    localparam real VDD_DEF   = 1.0;

    // Target voltage for one PWM bit. A 2-state argument folds X/Z to 0.
    function automatic real pwm_level(input bit level, input real vdd);
        return level ? vdd : 0.0;
    endfunction

endpackage

// File: rtl/pwm_analog_frontend_if.sv
// Signal bundle between the digital ramp logic and one PWM analog channel.
interface pwm_analog_frontend_if;

    logic pwm_i;    // PWM bitstream into the filter
    real  ain_i;    // analog input under conversion (comparator negative leg)
    real  filt_o;   // filtered PWM voltage (comparator positive leg)
    logic cmp_o;    // 1 when filt_o is above ain_i

    modport master (output pwm_i, ain_i, input  filt_o, cmp_o);
    modport slave  (input  pwm_i, ain_i, output filt_o, cmp_o);

endinterface

// File: rtl/lvds_comparator.sv
// Unclocked comparator with optional symmetric hysteresis band.
module lvds_comparator #(
    parameter real HYST = 0.0
) (
    input  logic rst_n,
    input  real  pos,
    input  real  neg,
    output logic cmp
);

    if (HYST == 0.0) begin : g_plain
        // Reset has nothing to clear without a hysteresis state.
        logic unused_rst;
        assign unused_rst = rst_n;

        // Strict compare so equal legs resolve to 0.
        assign cmp = (pos > neg);
    end else begin : g_hyst
        logic state;

        // Rise above the upper threshold, fall below the lower one, hold
        // inside the band; reset clears the held decision.
        always_latch begin
            if (pos > neg + HYST) begin
                state <= 1'b1;
            end else if (!rst_n || pos < neg - HYST) begin
                state <= 1'b0;
            end
        end

        assign cmp = state;
    end

endmodule

// File: rtl/rc_filter_stage.sv
// Clocked first-order discrete RC low-pass turning a PWM bit into a voltage.
module rc_filter_stage
    import pwm_frontend_pkg::*;
#(
    parameter real ALPHA = ALPHA_DEF,
    parameter real VDD   = VDD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm,
    output real  filt
);

    // Move a fraction ALPHA of the way toward the PWM target each edge;
    // reset drops the state to 0.0 without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 0.0;
        end else begin
            filt <= filt + ALPHA * (pwm_level(pwm, VDD) - filt);
        end
    end

endmodule

// File: rtl/pwm_analog_frontend.sv
// One PWM-DAC feedback channel: RC filter feeding a comparator against ain_i.
module pwm_analog_frontend
    import pwm_frontend_pkg::*;
#(
    parameter real ALPHA = ALPHA_DEF,
    parameter real VDD   = VDD_DEF,
    parameter real HYST  = 0.0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    pwm_analog_frontend_if.slave        bus
);

    // Reject parameter sets that would make the filter unstable or meaningless.
    if (!(ALPHA > 0.0 && ALPHA <= 1.0)) begin : g_bad_alpha
        $fatal(1, "pwm_analog_frontend: ALPHA must lie in (0.0, 1.0]");
    end
    if (VDD <= 0.0) begin : g_bad_vdd
        $fatal(1, "pwm_analog_frontend: VDD must be positive");
    end
    if (HYST < 0.0) begin : g_bad_hyst
        $fatal(1, "pwm_analog_frontend: HYST must be non-negative");
    end

    rc_filter_stage #(
        .ALPHA (ALPHA),
        .VDD   (VDD)
    ) u_filter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .pwm   (bus.pwm_i),
        .filt  (bus.filt_o)
    );

    // The filtered voltage is the positive comparator leg.
    lvds_comparator #(
        .HYST  (HYST)
    ) u_cmp (
        .rst_n (rst_ni),
        .pos   (bus.filt_o),
        .neg   (bus.ain_i),
        .cmp   (bus.cmp_o)
    );

endmodule

// File: tb/tb_pwm_analog_frontend.sv
// Self-checking bench for pwm_analog_frontend: slow ramp, duty ripple,
// unit-ALPHA register behaviour, hysteresis sweep and asynchronous reset.
module tb_pwm_analog_frontend;

    localparam real A_SLOW = 0.007;
    localparam real VDD_B  = 2.0;
    localparam real HYST_C = 0.05;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    pwm_analog_frontend_if ifa ();
    pwm_analog_frontend_if ifb ();
    pwm_analog_frontend_if ifc ();

    pwm_analog_frontend #(.ALPHA(A_SLOW), .VDD(1.0), .HYST(0.0)) u_a (
        .clk_i (clk), .rst_ni (rst_a), .bus (ifa));
    pwm_analog_frontend #(.ALPHA(1.0), .VDD(VDD_B), .HYST(0.0)) u_b (
        .clk_i (clk), .rst_ni (rst_b), .bus (ifb));
    pwm_analog_frontend #(.ALPHA(A_SLOW), .VDD(1.0), .HYST(HYST_C)) u_c (
        .clk_i (clk), .rst_ni (rst_c), .bus (ifc));

    typedef struct {
        logic pwm;
        real  ain;
        real  exp_filt;
        logic exp_cmp;
    } vec_t;

    vec_t tv [8];
    int   total = 0;
    int   bad   = 0;

    real  exp_v, prev, mn, mx, y0, ain_r;
    int   mono_bad, range_bad;
    logic st, p;

    // Closed-form response of a first-order stage after n constant-input edges.
    function automatic real rc_model(input real v, input real y_start, input real a, input int n);
        return v + (y_start - v) * $pow(1.0 - a, real'(n));
    endfunction

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic chk_r(input string name, input real act, input real exp, input real tol);
        total++;
        if (!(act >= exp - tol && act <= exp + tol)) begin
            bad++;
            $display("FAIL %s: got %.9f want %.9f (tol %g)", name, act, exp, tol);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{1'b1,  1.0,   2.0, 1'b1};
        tv[1] = '{1'b1,  2.0,   2.0, 1'b0};   // equal legs -> 0
        tv[2] = '{1'b0,  2.0,   0.0, 1'b0};
        tv[3] = '{1'b0, -0.5,   0.0, 1'b1};
        tv[4] = '{1'b0,  0.0,   0.0, 1'b0};   // equal at zero -> 0
        tv[5] = '{1'b1,  1.999, 2.0, 1'b1};
        tv[6] = '{1'b0, -0.001, 0.0, 1'b1};
        tv[7] = '{1'b1,  3.0,   2.0, 1'b0};

        // Reset held with clock running and pwm high: nothing may move.
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ifa.pwm_i = 1'b1; ifa.ain_i = 0.3;
        ifb.pwm_i = 1'b1; ifb.ain_i = -0.1;
        ifc.pwm_i = 1'b1; ifc.ain_i = 0.5;
        repeat (3) tick();
        chk_r("rst_a_filt", ifa.filt_o, 0.0, 0.0);
        chk_b("rst_a_cmp",  ifa.cmp_o, 1'b0);
        chk_r("rst_b_filt", ifb.filt_o, 0.0, 0.0);
        chk_b("rst_b_cmp",  ifb.cmp_o, 1'b1);
        chk_r("rst_c_filt", ifc.filt_o, 0.0, 0.0);
        chk_b("rst_c_cmp",  ifc.cmp_o, 1'b0);

        // Slow ramp toward 1.0 with ain = 0.3.
        #2 rst_a = 1'b1;
        prev = 0.0; mono_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            exp_v = rc_model(1.0, 0.0, A_SLOW, n);
            chk_r("ramp_filt", ifa.filt_o, exp_v, 1e-9);
            if (rabs(exp_v - 0.3) > 1e-9) chk_b("ramp_cmp", ifa.cmp_o, exp_v > 0.3);
            if (ifa.filt_o <= prev) mono_bad++;
            prev = ifa.filt_o;
        end
        chk_r("ramp_100", ifa.filt_o, 0.5046, 1e-3);
        chk_i("ramp_monotonic_violations", mono_bad, 0);

        // Further ramp, then an unaligned reset pulse.
        for (int n = 101; n <= 120; n++) tick();
        chk_r("ramp_120", ifa.filt_o, rc_model(1.0, 0.0, A_SLOW, 120), 1e-9);
        #2 rst_a = 1'b0;
        #1;
        chk_r("midrst_filt", ifa.filt_o, 0.0, 0.0);
        chk_b("midrst_cmp",  ifa.cmp_o, 1'b0);
        repeat (2) tick();
        chk_r("midrst_hold", ifa.filt_o, 0.0, 0.0);
        #2 rst_a = 1'b1;
        #1;
        chk_r("midrst_release", ifa.filt_o, 0.0, 0.0);
        tick();
        chk_r("midrst_first_edge", ifa.filt_o, A_SLOW, 1e-12);

        // 50 % duty toggling: steady state alternates 1/(2-a) and (1-a)/(2-a).
        mn = 10.0; mx = -10.0; range_bad = 0;
        for (int i = 0; i < 5000; i++) begin
            ifa.pwm_i = ~ifa.pwm_i;
            tick();
            if (ifa.filt_o < 0.0 || ifa.filt_o > 1.0) range_bad++;
            if (i >= 4600) begin
                if (ifa.filt_o < mn) mn = ifa.filt_o;
                if (ifa.filt_o > mx) mx = ifa.filt_o;
            end
        end
        chk_r("duty_max", mx, 1.0 / (2.0 - A_SLOW), 1e-6);
        chk_r("duty_min", mn, (1.0 - A_SLOW) / (2.0 - A_SLOW), 1e-6);
        chk_r("duty_center", (mx + mn) / 2.0, 0.5, 0.005);
        chk_r("duty_ripple", mx - mn, 0.0035, 1e-4);
        chk_i("duty_out_of_range", range_bad, 0);

        // Unit ALPHA, VDD = 2.0: table of pwm/ain pairs.
        #2 rst_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifb.pwm_i = tv[i].pwm;
            ifb.ain_i = tv[i].ain;
            tick();
            chk_r("tbl_filt", ifb.filt_o, tv[i].exp_filt, 0.0);
            chk_b("tbl_cmp",  ifb.cmp_o,  tv[i].exp_cmp);
        end

        // Unit ALPHA random: filt is VDD*pwm of the previous edge, cmp is strict compare.
        exp_v = VDD_B;
        for (int i = 0; i < 200; i++) begin
            p     = 1'($urandom_range(0, 1));
            ain_r = real'($urandom_range(0, 3000)) / 1000.0 - 0.5;
            ifb.pwm_i = p;
            ifb.ain_i = ain_r;
            #1;
            chk_b("rand_cmp_ain", ifb.cmp_o, exp_v > ain_r);
            tick();
            exp_v = p ? VDD_B : 0.0;
            chk_r("rand_filt", ifb.filt_o, exp_v, 0.0);
            chk_b("rand_cmp",  ifb.cmp_o, exp_v > ain_r);
        end

        // Hysteresis sweep around ain = 0.5: up past 0.55, back below 0.45.
        ifc.pwm_i = 1'b1;
        #2 rst_c = 1'b1;
        st = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            exp_v = rc_model(1.0, 0.0, A_SLOW, n);
            if (exp_v > 0.5 + HYST_C) st = 1'b1;
            else if (exp_v < 0.5 - HYST_C) st = 1'b0;
            chk_r("hyst_up_filt", ifc.filt_o, exp_v, 1e-9);
            if (rabs(exp_v - 0.55) > 1e-9 && rabs(exp_v - 0.45) > 1e-9)
                chk_b("hyst_up_cmp", ifc.cmp_o, st);
        end
        y0 = rc_model(1.0, 0.0, A_SLOW, 200);
        ifc.pwm_i = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            exp_v = rc_model(0.0, y0, A_SLOW, n);
            if (exp_v > 0.5 + HYST_C) st = 1'b1;
            else if (exp_v < 0.5 - HYST_C) st = 1'b0;
            chk_r("hyst_dn_filt", ifc.filt_o, exp_v, 1e-9);
            if (rabs(exp_v - 0.55) > 1e-9 && rabs(exp_v - 0.45) > 1e-9)
                chk_b("hyst_dn_cmp", ifc.cmp_o, st);
        end

        // Hysteresis reset: held decision cleared asynchronously.
        ifc.ain_i = 0.0;
        #1;
        chk_b("hyst_pre_rst", ifc.cmp_o, 1'b1);
        rst_c = 1'b0;
        #1;
        chk_r("hyst_rst_filt", ifc.filt_o, 0.0, 0.0);
        chk_b("hyst_rst_cmp",  ifc.cmp_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
